// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: sequences the IP, reads 64-bit instructions from ROM, offers them to decode.
// Latency: 1+ROM_LATENCY cycles trigger->offer; offers every 2 cycles with IFU_PREFETCH_EN defined.
// Backpressure: offer held stable while iDecodeBusy; 1-cycle gap after every accept or branch.
module instruction_fetch_unit #(
   parameter int ROM_ADDR_W  = 16,
   parameter int INSTR_W     = 64,
   parameter int ROM_LATENCY = 1
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  iTrigger,
   input  logic [ROM_ADDR_W-1:0] iInitialIP,
   output logic [ROM_ADDR_W-1:0] oRomAddress,
   output logic                  oRomReadEnable,
   input  logic [INSTR_W-1:0]    iRomData,
   output logic [INSTR_W-1:0]    oEncodedInstruction,
   output logic                  oInstructionAvailable,
   input  logic                  iDecodeBusy,
   input  logic                  iBranchTaken,
   input  logic [ROM_ADDR_W-1:0] iBranchTarget,
   output logic [ROM_ADDR_W-1:0] oCurrentIP,
   output logic                  oIdle
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_OFFER  = 3'd2,
      S_GAP    = 3'd3,
      S_HALTED = 3'd4
   } state_t;

   localparam int                     CNT_W    = 2;
   localparam logic [CNT_W-1:0]       CNT_LOAD = CNT_W'(ROM_LATENCY - 1);
   localparam logic [CNT_W-1:0]       CNT_ONE  = CNT_W'(1);
   localparam logic [ROM_ADDR_W-1:0]  IP_ONE   = ROM_ADDR_W'(1);

   state_t                  r_state;
   state_t                  w_next_state;
   logic [ROM_ADDR_W-1:0]   r_ip;
   logic [ROM_ADDR_W-1:0]   w_ip_next;
   logic [CNT_W-1:0]        r_cnt;
   logic [INSTR_W-1:0]      r_instr;
   logic [ROM_ADDR_W-1:0]   r_cur_ip;
   logic                    w_accept;
   logic                    w_is_end;
   logic                    w_active;
   logic                    w_branch;
   logic                    w_capture;
   logic                    w_load_pf;
   logic                    w_rom_en;
   logic [ROM_ADDR_W-1:0]   w_rom_addr;
   logic                    w_pf_vld;
   logic [INSTR_W-1:0]      w_pf_dat;

   assign w_accept = (r_state == S_OFFER) && !iDecodeBusy;
   assign w_is_end = (r_instr[INSTR_W-11:INSTR_W-16] == '0);
   assign w_active = (r_state == S_FETCH) || (r_state == S_OFFER) || (r_state == S_GAP);
   assign w_branch = iBranchTaken && w_active;

`ifdef IFU_PREFETCH_EN
   logic               r_pf_vld;
   logic [INSTR_W-1:0] r_pf_dat;
   logic               w_pf_clear;
   logic               w_pf_fill;

   // Any redirect or END makes the sequentially prefetched word useless.
   assign w_pf_clear = w_branch || (w_accept && w_is_end);
   assign w_pf_fill  = (r_state == S_OFFER) && !r_pf_vld && (r_cnt == '0);

   // Buffer holds IP+1, read while the current instruction waits in OFFER.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_pf_vld <= 1'b0;
         r_pf_dat <= '0;
      end else if (w_pf_clear) begin
         r_pf_vld <= 1'b0;
      end else if (w_pf_fill) begin
         r_pf_vld <= 1'b1;
         r_pf_dat <= iRomData;
      end else if (w_load_pf) begin
         r_pf_vld <= 1'b0;
      end
   end

   assign w_pf_vld = r_pf_vld;
   assign w_pf_dat = r_pf_dat;
`else
   assign w_pf_vld = 1'b0;
   assign w_pf_dat = '0;
`endif

   // State register.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next state, next IP and ROM port; END-on-accept beats a coincident branch.
   always_comb begin
      w_next_state = r_state;
      w_ip_next    = r_ip;
      w_capture    = 1'b0;
      w_load_pf    = 1'b0;
      w_rom_en     = 1'b0;
      w_rom_addr   = r_ip;
      case (r_state)
         S_IDLE, S_HALTED: begin
            if (iTrigger) begin
               w_ip_next    = iInitialIP;
               w_next_state = S_FETCH;
            end
         end
         S_FETCH: begin
            w_rom_en = 1'b1;
            if (iBranchTaken) begin
               w_ip_next    = iBranchTarget;
               w_next_state = S_GAP;
            end else if (r_cnt == '0) begin
               w_capture    = 1'b1;
               w_next_state = S_OFFER;
            end
         end
         S_OFFER: begin
`ifdef IFU_PREFETCH_EN
            w_rom_addr = r_ip + IP_ONE;
            w_rom_en   = !w_pf_vld;
`endif
            if (w_accept && w_is_end) begin
               w_next_state = S_HALTED;
            end else if (iBranchTaken) begin
               w_ip_next    = iBranchTarget;
               w_next_state = S_GAP;
            end else if (w_accept) begin
               w_ip_next    = r_ip + IP_ONE;
               w_next_state = S_GAP;
            end
         end
         S_GAP: begin
            if (iBranchTaken) begin
               w_ip_next    = iBranchTarget;
               w_next_state = S_GAP;
            end else if (w_pf_vld) begin
               w_load_pf    = 1'b1;
               w_next_state = S_OFFER;
            end else begin
               w_next_state = S_FETCH;
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // IP, offered instruction and the ROM latency counter (reloaded on every state entry).
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_ip     <= '0;
         r_cnt    <= '0;
         r_instr  <= '0;
         r_cur_ip <= '0;
      end else begin
         r_ip <= w_ip_next;
         if (w_capture) begin
            r_instr  <= iRomData;
            r_cur_ip <= r_ip;
         end else if (w_load_pf) begin
            r_instr  <= w_pf_dat;
            r_cur_ip <= r_ip;
         end
         if (w_next_state != r_state) begin
            r_cnt <= CNT_LOAD;
         end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_ONE;
         end
      end
   end

   assign oRomAddress           = w_rom_addr;
   assign oRomReadEnable        = w_rom_en;
   assign oEncodedInstruction   = r_instr;
   assign oInstructionAvailable = (r_state == S_OFFER);
   assign oCurrentIP            = r_cur_ip;
   assign oIdle                 = (r_state == S_IDLE) || (r_state == S_HALTED);

endmodule
